// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, keeps one instruction-memory request in flight,
// and feeds the IF/ID register (with a one-entry skid buffer for decode stalls).
module fetch_stage #(
    parameter int unsigned     XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter logic [31:0]     NOP_INSTR = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    input  logic            id_stall,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    output logic            if_id_valid,
    output logic [31:0]     if_id_instr,
    output logic [XLEN-1:0] if_id_pc,
    output logic [6:0]      if_id_opcode
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_HOLD,
        S_DISCARD
    } state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            skid_vld_q, skid_vld_d;
    logic [31:0]     skid_instr_q, skid_instr_d;
    logic [XLEN-1:0] skid_pc_q, skid_pc_d;
    logic            if_id_valid_q, if_id_valid_d;
    logic [31:0]     if_id_instr_q, if_id_instr_d;
    logic [XLEN-1:0] if_id_pc_q, if_id_pc_d;

    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] target;
    logic            accept;
    logic            flush;
    logic            load;
    logic [31:0]     load_instr;
    logic [XLEN-1:0] load_pc;

    assign pc_plus4 = pc_q + XLEN'(4);
    assign target   = branch_target & ~XLEN'(3);
    assign accept   = !id_stall || !if_id_valid_q;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        skid_vld_d   = skid_vld_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;
        flush        = 1'b0;
        load         = 1'b0;
        load_instr   = imem_rdata;
        load_pc      = pc_q;

        // A taken branch outranks every other event in every busy state.
        case (state_q)
            S_IDLE: state_d = S_ISSUE;
            S_ISSUE: begin
                if (branch_taken) begin
                    pc_d    = target;
                    flush   = 1'b1;
                    state_d = S_DISCARD;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (branch_taken) begin
                    pc_d    = target;
                    flush   = 1'b1;
                    state_d = imem_rvalid ? S_ISSUE : S_DISCARD;
                end else if (imem_rvalid) begin
                    pc_d = pc_plus4;
                    if (accept) begin
                        load    = 1'b1;
                        state_d = S_ISSUE;
                    end else begin
                        skid_vld_d   = 1'b1;
                        skid_instr_d = imem_rdata;
                        skid_pc_d    = pc_q;
                        state_d      = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (branch_taken) begin
                    pc_d       = target;
                    flush      = 1'b1;
                    skid_vld_d = 1'b0;
                    state_d    = S_ISSUE;
                end else if (!id_stall && skid_vld_q) begin
                    load       = 1'b1;
                    load_instr = skid_instr_q;
                    load_pc    = skid_pc_q;
                    skid_vld_d = 1'b0;
                    state_d    = S_ISSUE;
                end
            end
            S_DISCARD: begin
                if (branch_taken) begin
                    pc_d = target;
                end
                if (imem_rvalid) begin
                    state_d = S_ISSUE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // IF/ID: flush, else load, else hold on stall, else the entry is consumed.
        if (flush) begin
            if_id_valid_d = 1'b0;
            if_id_instr_d = NOP_INSTR;
            if_id_pc_d    = if_id_pc_q;
        end else if (load) begin
            if_id_valid_d = 1'b1;
            if_id_instr_d = load_instr;
            if_id_pc_d    = load_pc;
        end else if (id_stall) begin
            if_id_valid_d = if_id_valid_q;
            if_id_instr_d = if_id_instr_q;
            if_id_pc_d    = if_id_pc_q;
        end else begin
            if_id_valid_d = 1'b0;
            if_id_instr_d = NOP_INSTR;
            if_id_pc_d    = if_id_pc_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            pc_q          <= RESET_PC;
            skid_vld_q    <= 1'b0;
            skid_instr_q  <= '0;
            skid_pc_q     <= '0;
            if_id_valid_q <= 1'b0;
            if_id_instr_q <= NOP_INSTR;
            if_id_pc_q    <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            skid_vld_q    <= skid_vld_d;
            skid_instr_q  <= skid_instr_d;
            skid_pc_q     <= skid_pc_d;
            if_id_valid_q <= if_id_valid_d;
            if_id_instr_q <= if_id_instr_d;
            if_id_pc_q    <= if_id_pc_d;
        end
    end

    assign imem_req     = (state_q == S_ISSUE);
    assign imem_addr    = pc_q;
    assign if_id_valid  = if_id_valid_q;
    assign if_id_instr  = if_id_instr_q;
    assign if_id_pc     = if_id_pc_q;
    assign if_id_opcode = if_id_instr_q[6:0];

endmodule
